// File: rtl/board_pkg.sv
// Shared types and defaults for the whack-a-mole round sequencer.
package board_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_UP   = 3'd2,
        ST_HIT  = 3'd3,
        ST_MISS = 3'd4,
        ST_OVER = 3'd5
    } state_e;

    localparam int unsigned N_MOLES_DEF    = 8;
    localparam logic [27:0] UP_INIT_DEF    = 28'd100_000_000;
    localparam logic [27:0] UP_MIN_DEF     = 28'd30_000_000;
    localparam logic [27:0] UP_STEP_DEF    = 28'd5_000_000;
    localparam logic [27:0] GAP_TIME_DEF   = 28'd50_000_000;
    localparam logic [27:0] FLASH_TIME_DEF = 28'd25_000_000;
    localparam int unsigned MAX_MISS_DEF   = 4;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used to pick the next mole.
module mole_lfsr
    import board_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/board_ctrl.sv
// Whack-a-mole round sequencer: times mole windows via the board timer,
// judges button presses, and tracks score, misses and up-window length.
module board_ctrl
    import board_pkg::*;
#(
    parameter int unsigned N_MOLES    = N_MOLES_DEF,
    parameter logic [27:0] UP_INIT    = UP_INIT_DEF,
    parameter logic [27:0] UP_MIN     = UP_MIN_DEF,
    parameter logic [27:0] UP_STEP    = UP_STEP_DEF,
    parameter logic [27:0] GAP_TIME   = GAP_TIME_DEF,
    parameter logic [27:0] FLASH_TIME = FLASH_TIME_DEF,
    parameter int unsigned MAX_MISS   = MAX_MISS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_MOLES-1:0] btn_hit,
    input  logic               time_trigger,
    output logic               timer_load,
    output logic [27:0]        timer_loadval,
    output logic [N_MOLES-1:0] mole_mask,
    output logic               flash_hit,
    output logic               flash_miss,
    output logic [7:0]         score,
    output logic [3:0]         misses,
    output logic               game_over,
    output logic               busy
);

    localparam int unsigned IDX_W = clog2(N_MOLES);

    logic [15:0] lfsr;
    logic        unused_lfsr_hi;

    mole_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:IDX_W];

    state_e             state_q, state_d;
    logic [27:0]        up_time_q, up_time_d;
    logic [IDX_W-1:0]   prev_idx_q, prev_idx_d;
    logic               timer_load_q, timer_load_d;
    logic [27:0]        timer_loadval_q, timer_loadval_d;
    logic [N_MOLES-1:0] mole_mask_q, mole_mask_d;
    logic               flash_hit_q, flash_hit_d;
    logic               flash_miss_q, flash_miss_d;
    logic [7:0]         score_q, score_d;
    logic [3:0]         misses_q, misses_d;
    logic               game_over_q, game_over_d;
    logic               busy_q, busy_d;

    logic               trig_ok;
    logic [IDX_W-1:0]   pick_idx;
    logic [28:0]        up_dec;

    always_comb begin
        state_d         = state_q;
        up_time_d       = up_time_q;
        prev_idx_d      = prev_idx_q;
        timer_load_d    = 1'b0;
        timer_loadval_d = timer_loadval_q;
        mole_mask_d     = mole_mask_q;
        score_d         = score_q;
        misses_d        = misses_q;

        // A trigger arriving while a fresh load is on the wire belongs to the old count
        trig_ok = time_trigger & ~timer_load_q;

        pick_idx = lfsr[IDX_W-1:0];
        if (pick_idx == prev_idx_q) pick_idx = pick_idx + IDX_W'(1);

        up_dec = {1'b0, up_time_q} - {1'b0, UP_STEP};

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score_d   = '0;
                    misses_d  = '0;
                    up_time_d = UP_INIT;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (trig_ok) begin
                    mole_mask_d           = '0;
                    mole_mask_d[pick_idx] = 1'b1;
                    prev_idx_d            = pick_idx;
                    state_d               = ST_UP;
                end
            end
            ST_UP: begin
                if (btn_hit == mole_mask_q) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    if (up_dec[28] || (up_dec[27:0] < UP_MIN)) up_time_d = UP_MIN;
                    else                                        up_time_d = up_dec[27:0];
                    mole_mask_d = '0;
                    state_d     = ST_HIT;
                end else if ((btn_hit != '0) || trig_ok) begin
                    misses_d    = misses_q + 4'd1;
                    mole_mask_d = '0;
                    state_d     = ST_MISS;
                end
            end
            ST_HIT: begin
                if (trig_ok) state_d = ST_GAP;
            end
            ST_MISS: begin
                if (trig_ok) state_d = (misses_q == 4'(MAX_MISS)) ? ST_OVER : ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                ST_GAP: begin
                    timer_load_d    = 1'b1;
                    timer_loadval_d = GAP_TIME;
                end
                ST_UP: begin
                    timer_load_d    = 1'b1;
                    timer_loadval_d = up_time_d;
                end
                ST_HIT, ST_MISS: begin
                    timer_load_d    = 1'b1;
                    timer_loadval_d = FLASH_TIME;
                end
                default: timer_load_d = 1'b0;
            endcase
        end

        flash_hit_d  = (state_d == ST_HIT);
        flash_miss_d = (state_d == ST_MISS);
        game_over_d  = (state_d == ST_OVER);
        busy_d       = (state_d != ST_IDLE) && (state_d != ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            up_time_q       <= UP_INIT;
            prev_idx_q      <= '0;
            timer_load_q    <= 1'b0;
            timer_loadval_q <= '0;
            mole_mask_q     <= '0;
            flash_hit_q     <= 1'b0;
            flash_miss_q    <= 1'b0;
            score_q         <= '0;
            misses_q        <= '0;
            game_over_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            up_time_q       <= up_time_d;
            prev_idx_q      <= prev_idx_d;
            timer_load_q    <= timer_load_d;
            timer_loadval_q <= timer_loadval_d;
            mole_mask_q     <= mole_mask_d;
            flash_hit_q     <= flash_hit_d;
            flash_miss_q    <= flash_miss_d;
            score_q         <= score_d;
            misses_q        <= misses_d;
            game_over_q     <= game_over_d;
            busy_q          <= busy_d;
        end
    end

    assign timer_load    = timer_load_q;
    assign timer_loadval = timer_loadval_q;
    assign mole_mask     = mole_mask_q;
    assign flash_hit     = flash_hit_q;
    assign flash_miss    = flash_miss_q;
    assign score         = score_q;
    assign misses        = misses_q;
    assign game_over     = game_over_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl with a stand-in count-down board timer.
module tb_board_ctrl;

    localparam int unsigned NM         = 8;
    localparam int          T_UP_INIT  = 20;
    localparam int          T_UP_MIN   = 8;
    localparam int          T_UP_STEP  = 5;
    localparam int          T_GAP      = 10;
    localparam int          T_FLASH    = 4;
    localparam int          T_MAX_MISS = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NM-1:0] btn_hit = '0;
    logic          time_trigger;
    logic          timer_load;
    logic [27:0]   timer_loadval;
    logic [NM-1:0] mole_mask;
    logic          flash_hit, flash_miss, game_over, busy;
    logic [7:0]    score;
    logic [3:0]    misses;

    board_ctrl #(
        .N_MOLES    (NM),
        .UP_INIT    (28'(T_UP_INIT)),
        .UP_MIN     (28'(T_UP_MIN)),
        .UP_STEP    (28'(T_UP_STEP)),
        .GAP_TIME   (28'(T_GAP)),
        .FLASH_TIME (28'(T_FLASH)),
        .MAX_MISS   (T_MAX_MISS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .btn_hit       (btn_hit),
        .time_trigger  (time_trigger),
        .timer_load    (timer_load),
        .timer_loadval (timer_loadval),
        .mole_mask     (mole_mask),
        .flash_hit     (flash_hit),
        .flash_miss    (flash_miss),
        .score         (score),
        .misses        (misses),
        .game_over     (game_over),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Board timer stand-in: not reset by rst_n, pulses once when the count expires
    int tcnt = 0;
    always @(posedge clk) begin
        if (timer_load)    tcnt <= int'(timer_loadval);
        else if (tcnt > 0) tcnt <= tcnt - 1;
    end
    assign time_trigger = (tcnt == 1);

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model of the game rules
    typedef enum {M_IDLE, M_GAP, M_UP, M_HIT, M_MISS, M_OVER} mphase_e;
    mphase_e     m_ph = M_IDLE;
    int          m_up, m_score, m_miss, m_prev, m_mask, m_loadval;
    bit          m_load;
    int unsigned m_lfsr;

    function automatic void model_step(input bit rn, input bit st, input int btn, input bit trig);
        mphase_e nx;
        int      idx;
        bit      ok;
        bit      fb;
        if (!rn) begin
            m_ph = M_IDLE; m_up = T_UP_INIT; m_lfsr = 32'hACE1; m_prev = 0;
            m_mask = 0; m_score = 0; m_miss = 0; m_load = 0; m_loadval = 0;
            return;
        end
        ok = trig && !m_load;
        nx = m_ph;
        case (m_ph)
            M_IDLE, M_OVER: if (st) begin
                m_score = 0; m_miss = 0; m_up = T_UP_INIT; nx = M_GAP;
            end
            M_GAP: if (ok) begin
                idx = int'(m_lfsr % NM);
                if (idx == m_prev) idx = (idx + 1) % NM;
                m_mask = 1 << idx; m_prev = idx; nx = M_UP;
            end
            M_UP: begin
                if (btn == m_mask) begin
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_up = (m_up - T_UP_STEP < T_UP_MIN) ? T_UP_MIN : m_up - T_UP_STEP;
                    m_mask = 0; nx = M_HIT;
                end else if (btn != 0 || ok) begin
                    m_miss++; m_mask = 0; nx = M_MISS;
                end
            end
            M_HIT:  if (ok) nx = M_GAP;
            M_MISS: if (ok) nx = (m_miss == T_MAX_MISS) ? M_OVER : M_GAP;
            default: nx = M_IDLE;
        endcase
        m_load = 0;
        if (nx != m_ph) begin
            case (nx)
                M_GAP:          begin m_load = 1; m_loadval = T_GAP;   end
                M_UP:           begin m_load = 1; m_loadval = m_up;    end
                M_HIT, M_MISS:  begin m_load = 1; m_loadval = T_FLASH; end
                default: ;
            endcase
        end
        m_ph = nx;
        fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        m_lfsr = ((m_lfsr << 1) | 32'(fb)) & 32'hFFFF;
    endfunction

    task automatic compare_all();
        check("mole_mask", int'(mole_mask), m_mask);
        check("timer_load", int'(timer_load), int'(m_load));
        if (m_load) check("timer_loadval", int'(timer_loadval), m_loadval);
        check("flash_hit", int'(flash_hit), int'(m_ph == M_HIT));
        check("flash_miss", int'(flash_miss), int'(m_ph == M_MISS));
        check("score", int'(score), m_score);
        check("misses", int'(misses), m_miss);
        check("game_over", int'(game_over), int'(m_ph == M_OVER));
        check("busy", int'(busy), int'(m_ph != M_IDLE && m_ph != M_OVER));
    endtask

    // Mole-pick statistics gathered from the DUT outputs
    bit          track_en = 0;
    bit          have_pick = 0;
    int          last_idx = 0;
    int          picks = 0;
    logic [NM-1:0] seen = '0;
    logic [NM-1:0] last_mask = '0;

    task automatic cycle(input bit rn, input bit st, input logic [NM-1:0] btn);
        int idx;
        rst_n = rn; start = st; btn_hit = btn;
        model_step(rn, st, int'(btn), time_trigger);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (track_en && mole_mask != '0 && last_mask == '0) begin
            idx = -1;
            for (int b = 0; b < NM; b++) if (mole_mask[b]) idx = b;
            if (have_pick) check("pick_no_repeat", int'(idx != last_idx), 1);
            seen |= mole_mask;
            last_idx = idx; have_pick = 1; picks++;
        end
        last_mask = mole_mask;
    endtask

    task automatic wait_phase(input mphase_e tgt, input string nm);
        int n;
        n = 0;
        while (m_ph != tgt && n < 300) begin
            cycle(1'b1, 1'b0, '0);
            n++;
        end
        check(nm, int'(m_ph == tgt), 1);
    endtask

    task automatic hit_round();
        wait_phase(M_UP, "wait_up");
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, NM'(m_mask));
    endtask

    typedef struct {
        bit            rn;
        bit            st;
        logic [NM-1:0] btn;
        bit            e_load;
        int            e_val;
        bit            e_busy;
        bit            e_over;
    } vec_t;

    vec_t tbl[6];
    int   exp_up[4];
    logic [NM-1:0] mm;
    bit   r_rn, r_st;
    logic [NM-1:0] r_btn;

    initial begin
        tbl[0] = '{0, 0, 8'h00, 0, 0,  0, 0};
        tbl[1] = '{0, 1, 8'hFF, 0, 0,  0, 0};
        tbl[2] = '{1, 0, 8'h0F, 0, 0,  0, 0};
        tbl[3] = '{1, 1, 8'h00, 1, 10, 1, 0};
        tbl[4] = '{1, 0, 8'h00, 0, 0,  1, 0};
        tbl[5] = '{1, 1, 8'h01, 0, 0,  1, 0};
        exp_up = '{15, 10, 8, 8};

        // Reset, idle inputs ignored, start loads the gap time
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].rn, tbl[i].st, tbl[i].btn);
            check("tbl_load", int'(timer_load), int'(tbl[i].e_load));
            if (tbl[i].e_load) check("tbl_loadval", int'(timer_loadval), tbl[i].e_val);
            check("tbl_busy", int'(busy), int'(tbl[i].e_busy));
            check("tbl_over", int'(game_over), int'(tbl[i].e_over));
        end

        // First mole and a sequence of hits shrinking the window to its floor
        wait_phase(M_UP, "wait_first_up");
        check("first_up_load", int'(timer_load), 1);
        check("first_up_val", int'(timer_loadval), 20);
        check("first_onehot", $countones(mole_mask), 1);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, NM'(m_mask));
        check("hit_flash", int'(flash_hit), 1);
        check("hit_score", int'(score), 1);
        for (int k = 0; k < 4; k++) begin
            wait_phase(M_UP, "wait_up_k");
            check("up_shrink", int'(timer_loadval), exp_up[k]);
            cycle(1'b1, 1'b0, '0);
            cycle(1'b1, 1'b0, NM'(m_mask));
        end
        check("score_after_hits", int'(score), 5);

        // Timeout miss, wrong-button miss, third miss ends the game
        wait_phase(M_UP, "wait_up_m1");
        wait_phase(M_MISS, "wait_miss1");
        check("miss1_count", int'(misses), 1);
        check("miss1_flash", int'(flash_miss), 1);
        wait_phase(M_UP, "wait_up_m2");
        cycle(1'b1, 1'b0, '0);
        mm = NM'(m_mask);
        cycle(1'b1, 1'b0, {mm[NM-2:0], mm[NM-1]});
        check("miss2_count", int'(misses), 2);
        wait_phase(M_UP, "wait_up_m3");
        wait_phase(M_MISS, "wait_miss3");
        wait_phase(M_OVER, "wait_over");
        check("over_flag", int'(game_over), 1);
        check("over_score", int'(score), 5);
        check("over_misses", int'(misses), 3);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, NM'($urandom_range(1, 255)));
        check("over_hold_score", int'(score), 5);

        // Hit coinciding with the window-expiry trigger resolves as a hit
        cycle(1'b1, 1'b1, '0);
        check("restart_score", int'(score), 0);
        check("restart_misses", int'(misses), 0);
        wait_phase(M_UP, "wait_up_coinc");
        for (int n = 0; n < 60 && !time_trigger; n++) cycle(1'b1, 1'b0, '0);
        check("coinc_trig_seen", int'(time_trigger), 1);
        cycle(1'b1, 1'b0, NM'(m_mask));
        check("coinc_hit", int'(flash_hit), 1);
        check("coinc_not_miss", int'(flash_miss), 0);

        // Score saturation and pick statistics over many rounds
        track_en = 1;
        for (int r = 0; r < 255; r++) hit_round();
        check("score_sat", int'(score), 255);
        check("sat_flash", int'(flash_hit), 1);
        check("pick_count", int'(picks >= 200), 1);
        check("all_holes_seen", int'(seen), 8'hFF);
        track_en = 0;

        // Reset mid-UP; the stale timer expiry is ignored afterwards
        wait_phase(M_UP, "wait_up_rst");
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        check("rst_mask", int'(mole_mask), 0);
        check("rst_score", int'(score), 0);
        check("rst_misses", int'(misses), 0);
        check("rst_load", int'(timer_load), 0);
        check("rst_busy", int'(busy), 0);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, '0);
        check("post_rst_idle", int'(busy), 0);
        cycle(1'b1, 1'b1, '0);
        check("post_rst_start_load", int'(timer_load), 1);
        check("post_rst_start_val", int'(timer_loadval), 10);

        // Randomised play against the model
        for (int i = 0; i < 3000; i++) begin
            r_rn  = ($urandom_range(0, 499) != 0);
            r_st  = ($urandom_range(0, 7) == 0);
            r_btn = '0;
            if (m_ph == M_UP) begin
                if ($urandom_range(0, 5) == 0)
                    r_btn = ($urandom_range(0, 1) == 1) ? NM'(m_mask) : NM'($urandom_range(1, 255));
            end else if ($urandom_range(0, 9) == 0) begin
                r_btn = NM'($urandom_range(1, 255));
            end
            cycle(r_rn, r_st, r_btn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/board_ctrl.md
Name: board_ctrl

Overview:
Game-round sequencer for the whack-a-mole board. It drives the board count-down timer (load/loadval in, time_trigger back) to time mole up-windows, gaps and hit-flash intervals. It picks a pseudo-random mole, judges button hits against it, keeps score and miss count, and shortens the up-window as the score rises. It sits between the debounced button front end and the LED/7-seg display logic.

Parameters:
N_MOLES, 8, number of holes/buttons; must be a power of two, 2..16
UP_INIT, 28'd100_000_000, initial mole up-window in clk cycles (1 s at 100 MHz)
UP_MIN, 28'd30_000_000, floor for the up-window
UP_STEP, 28'd5_000_000, up-window decrement per successful hit
GAP_TIME, 28'd50_000_000, dark interval between moles
FLASH_TIME, 28'd25_000_000, hit/miss indication interval
MAX_MISS, 4, misses that end the game (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; starts a game from IDLE or OVER
btn_hit  in  N_MOLES  single-cycle debounced press pulses, one bit per hole
time_trigger  in  1  pulse from board timer at count zero
timer_load  out  1  one-cycle load strobe to board timer
timer_loadval  out  28  value to load; valid whenever timer_load=1
mole_mask  out  N_MOLES  one-hot lit mole; all zero when no mole is up
flash_hit  out  1  high during HIT flash
flash_miss  out  1  high during MISS flash
score  out  8  successful hits, saturating at 255
misses  out  4  misses this game
game_over  out  1  high in OVER state
busy  out  1  high in any state except IDLE/OVER

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All outputs 0. up_time=UP_INIT. LFSR=16'hACE1. prev_idx=0.
- States: IDLE, GAP, UP, HIT, MISS, OVER. Every state change into GAP/UP/HIT/MISS registers timer_load=1 for exactly one cycle, with timer_loadval = GAP_TIME / up_time / FLASH_TIME / FLASH_TIME respectively.
- time_trigger is honoured only in GAP/UP/HIT/MISS and only when timer_load was 0 on the same cycle. This guard blocks stale triggers. It is ignored elsewhere.
- IDLE/OVER --start--> GAP. Clear score and misses, set up_time=UP_INIT.
- GAP --trigger--> UP.
  - Mole index idx = LFSR[log2(N_MOLES)-1:0]. If idx==prev_idx, idx = idx+1 (mod N_MOLES).
  - mole_mask = 1<<idx; prev_idx = idx.
- UP:
  - btn_hit == mole_mask (exactly the lit bit) -> HIT.
  - Any other nonzero btn_hit -> MISS.
  - trigger with btn_hit==0 -> MISS.
  - A hit and a trigger in the same cycle resolve as a hit.
  - mole_mask clears on leaving UP.
- HIT entry:
  - score = sat(score+1).
  - up_time = max(UP_MIN, up_time-UP_STEP). Compute in 29 bits so no underflow wrap.
  - flash_hit=1 while in HIT.
- MISS entry: misses+1. flash_miss=1 while in MISS.
- HIT --trigger--> GAP.
- MISS --trigger--> OVER if misses==MAX_MISS, else GAP.
- OVER: game_over=1. score and misses hold until next start.
- start outside IDLE/OVER is ignored. btn_hit outside UP is ignored.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every cycle including IDLE, so seed entropy comes from press timing. Never all-zero.
- All outputs are registered; mole_mask is visible the cycle after the GAP trigger.
- rst_n low mid-game: IDLE next edge, no timer_load issued. The timer keeps counting, and its eventual trigger is ignored in IDLE.

Decomposition:
- Package board_pkg:
  - state enum encoding (3 bits).
  - Default timing constants.
  - LFSR seed and tap mask.
  - Helper function clog2 for mole-index width.
- One sub-module: mole_lfsr. Inputs clk, rst_n; output lfsr[15:0]; free-running.
- Everything else lives in board_ctrl.

Test Plan:
Bench parameters: UP_INIT=20, UP_MIN=8, UP_STEP=5, GAP_TIME=10, FLASH_TIME=4, MAX_MISS=3. board_timer is instantiated and connected.
- Reset, then start pulse -> timer_load=1 with loadval=10 one cycle later. After the trigger, mole_mask is one-hot and timer_loadval=20.
- Press the lit bit mid-UP -> HIT, flash_hit=1, score=1. Next UP loads 15. Three more hits load 10, then 8, then 8 (floor holds).
- No press in UP -> trigger gives MISS, misses=1. Wrong bit pressed -> MISS, misses=2. Third miss -> OVER, game_over=1, score held.
- Force btn_hit on the same cycle as time_trigger in UP -> HIT, not MISS.
- Force score to 255, then hit -> score stays 255. 200 consecutive mole picks -> no index repeats back-to-back and all 8 indices appear.
- Assert rst_n=0 during UP -> IDLE, mole_mask=0, all counters 0. The late trigger produces no state change. start still works afterwards.
